// File: rtl/fetch_pc.sv
// fetch_pc: program counter and instruction-fetch stage for the MIPS core.
// Issues word fetches over a req/ack handshake. Presents fetched words with
// their PC+4 at the IF/ID boundary. Redirects on jr > jump > taken branch.
// Optional feature macro: PC_ALIGN_CHECK_EN (flags misaligned jr targets on
// align_err). When undefined, align_err is tied low.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] instr_in,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  input  logic [31:0] redir_pc4,
  input  logic        br_take,
  input  logic [31:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        align_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        align_err_q, align_err_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic signed [31:0] br_byte_off;

  // Redirect target with jr > jump > branch priority; jr target is word-aligned.
  function automatic logic [31:0] redirect_target(
    input logic        f_jr,
    input logic        f_jump,
    input logic [31:0] f_jr_target,
    input logic [31:0] f_redir_pc4,
    input logic [25:0] f_index,
    input logic signed [31:0] f_br_byte_off
  );
    logic [31:0] t;
    if (f_jr)
      t = f_jr_target & 32'hFFFF_FFFC;
    else if (f_jump)
      t = {f_redir_pc4[31:28], f_index, 2'b00};
    else
      t = f_redir_pc4 + $unsigned(f_br_byte_off);
    return t;
  endfunction

  assign redirect    = jr | jump | br_take;
  assign br_byte_off = $signed(br_offset) <<< 2;
  assign target      = redirect_target(jr, jump, jr_target, redir_pc4,
                                       jump_index, br_byte_off);
  assign pc_plus4    = pc_q + 32'd4;

  // Next-state, next-pc and IF/ID / skid register updates.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc4_d     = if_pc4_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    // Downstream consumed the current word when not stalled; nothing new
    // arriving means the boundary goes empty.
    if (!stall)
      if_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem_ack ? REQ : DISCARD;
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (stall) begin
            skid_vld_d   = 1'b1;
            skid_instr_d = instr_in;
            skid_pc4_d   = pc_plus4;
            state_d      = HOLD;
          end else begin
            if_valid_d = 1'b1;
            if_instr_d = instr_in;
            if_pc4_d   = pc_plus4;
          end
        end
      end
      DISCARD: begin
        // The in-flight word belongs to the old path; last redirect wins.
        if (redirect)
          pc_d = target;
        if (imem_ack)
          state_d = REQ;
      end
      HOLD: begin
        if (redirect) begin
          skid_vld_d = 1'b0;
          pc_d       = target;
          state_d    = REQ;
        end else if (!stall) begin
          if (skid_vld_q) begin
            if_valid_d = 1'b1;
            if_instr_d = skid_instr_q;
            if_pc4_d   = skid_pc4_q;
          end
          skid_vld_d = 1'b0;
          state_d    = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any redirect flushes the boundary, overriding stall.
    if (redirect)
      if_valid_d = 1'b0;
  end

  // Registered fetch interface: address is held while a discarded fetch is
  // outstanding, otherwise it tracks the next pc.
  always_comb begin
    req_d  = (state_d == REQ) || (state_d == DISCARD);
    addr_d = (state_d == DISCARD) ? addr_q : pc_d;
  end

`ifdef PC_ALIGN_CHECK_EN
  // Flag a misaligned jr target when jr wins the redirect priority.
  always_comb begin
    align_err_d = jr & (jr_target[1:0] != 2'b00);
  end
`else
  // Alignment checking disabled: jr_target[1:0] is ignored.
  always_comb begin
    align_err_d = 1'b0;
  end
`endif

  // Control and output state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= 32'd0;
      if_pc4_q    <= 32'd0;
      skid_vld_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc4_q    <= if_pc4_d;
      skid_vld_q  <= skid_vld_d;
      align_err_q <= align_err_d;
    end
  end

  // Skid data needs no reset; its validity is tracked by skid_vld_q.
  always_ff @(posedge clk) begin
    skid_instr_q <= skid_instr_d;
    skid_pc4_q   <= skid_pc4_d;
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc4    = if_pc4_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed, table-driven bench for fetch_pc.
module tb_fetch_pc;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] instr_in;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [31:0] redir_pc4;
  logic        br_take;
  logic [31:0] br_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        align_err;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic ALN = 1'b1;
`else
  localparam logic ALN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_pc #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_in(instr_in), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc4(if_pc4), .redir_pc4(redir_pc4), .br_take(br_take),
    .br_offset(br_offset), .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target), .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: the word at address a is a ^ 0xC0DE0000.
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign instr_in = w(imem_addr);

  typedef struct {
    logic        stall, ack, br, jmp, jrr;
    logic [31:0] redir, off;
    logic [25:0] idx;
    logic [31:0] jrt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr, e_pc4;
    logic        e_aln;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic s, input logic a, input logic b, input logic j, input logic r,
    input logic [31:0] rd, input logic [31:0] of, input logic [25:0] ix,
    input logic [31:0] jt, input logic erq, input logic [31:0] ead,
    input logic ev, input logic [31:0] ei, input logic [31:0] ep,
    input logic eal);
    vec_t v;
    v.stall = s; v.ack = a; v.br = b; v.jmp = j; v.jrr = r;
    v.redir = rd; v.off = of; v.idx = ix; v.jrt = jt;
    v.e_req = erq; v.e_addr = ead; v.e_vld = ev; v.e_instr = ei;
    v.e_pc4 = ep; v.e_aln = eal;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic erq, input logic [31:0] ead,
                         input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                         input logic eal);
    chk({tag, ".imem_req"},  {31'd0, imem_req},  {31'd0, erq});
    chk({tag, ".imem_addr"}, imem_addr,          ead);
    chk({tag, ".if_valid"},  {31'd0, if_valid},  {31'd0, ev});
    chk({tag, ".if_instr"},  if_instr,           ei);
    chk({tag, ".if_pc4"},    if_pc4,             ep);
    chk({tag, ".align_err"}, {31'd0, align_err}, {31'd0, eal});
  endtask

  task automatic zero_inputs();
    stall = 0; imem_ack = 0; br_take = 0; jump = 0; jr = 0;
    redir_pc4 = 0; br_offset = 0; jump_index = 0; jr_target = 0;
  endtask

  localparam logic [31:0] RJ  = 32'h4000_0010;
  localparam logic [25:0] IX  = 26'h000_0040;
  localparam logic [31:0] JT  = 32'h4000_0100;
  localparam logic [31:0] M2  = 32'hFFFF_FFFE;

  initial begin
    reset_n = 1'b0;
    zero_inputs();

    // Table: inputs applied before an edge, expected outputs after it.
    //          s a b j r  redir   off  idx  jrt            req addr           v  instr             pc4           aln
    vq.push_back(mk(0,0,0,0,0, 0,    0,   0,  0,            1, 32'h0,          0, 32'h0,           32'h0,        0)); // v0 IDLE->REQ
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'h4,          1, w(32'h0),        32'h4,        0)); // v1
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'h8,          1, w(32'h4),        32'h8,        0));
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'hC,          1, w(32'h8),        32'hC,        0));
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'h10,         1, w(32'hC),        32'h10,       0)); // v4
    vq.push_back(mk(1,1,0,0,0, 0,    0,   0,  0,            0, 32'h14,         1, w(32'hC),        32'h10,       0)); // v5 skid
    vq.push_back(mk(1,1,0,0,0, 0,    0,   0,  0,            0, 32'h14,         1, w(32'hC),        32'h10,       0));
    vq.push_back(mk(1,1,0,0,0, 0,    0,   0,  0,            0, 32'h14,         1, w(32'hC),        32'h10,       0));
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'h14,         1, w(32'h10),       32'h14,       0)); // v8 unskid
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'h18,         1, w(32'h14),       32'h18,       0));
    vq.push_back(mk(0,1,0,1,0, RJ,   0,   IX, 0,            1, JT,             0, w(32'h14),       32'h18,       0)); // v10 jump
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, JT+4,           1, w(JT),           JT+4,         0));
    vq.push_back(mk(0,0,1,0,0, 32'h100, M2, 0, 0,           1, JT+4,           0, w(JT),           JT+4,         0)); // v12 br, no ack
    vq.push_back(mk(0,0,0,0,0, 0,    0,   0,  0,            1, JT+4,           0, w(JT),           JT+4,         0));
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'hF8,         0, w(JT),           JT+4,         0)); // v14 discarded ack
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'hFC,         1, w(32'hF8),       32'hFC,       0));
    vq.push_back(mk(0,1,1,1,1, RJ,   M2,  IX, 32'h2002,     1, 32'h2000,       0, w(32'hF8),       32'hFC,       ALN)); // v16 all
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'h2004,       1, w(32'h2000),     32'h2004,     0));
    vq.push_back(mk(0,1,0,0,1, 0,    0,   0,  32'hFFFF_FFFC,1, 32'hFFFF_FFFC,  0, w(32'h2000),     32'h2004,     0)); // v18
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'h0,          1, w(32'hFFFF_FFFC),32'h0,        0)); // v19 wrap
    vq.push_back(mk(0,0,0,0,0, 0,    0,   0,  0,            1, 32'h0,          0, w(32'hFFFF_FFFC),32'h0,        0));
    vq.push_back(mk(1,1,0,0,0, 0,    0,   0,  0,            0, 32'h4,          0, w(32'hFFFF_FFFC),32'h0,        0)); // v21 skid
    vq.push_back(mk(1,0,0,1,0, RJ,   0,   IX, 0,            1, JT,             0, w(32'hFFFF_FFFC),32'h0,        0)); // v22 redirect in HOLD
    vq.push_back(mk(0,0,0,0,0, 0,    0,   0,  0,            1, JT,             0, w(32'hFFFF_FFFC),32'h0,        0));
    vq.push_back(mk(0,0,1,0,0, 32'h100, 32'h4, 0, 0,        1, JT,             0, w(32'hFFFF_FFFC),32'h0,        0)); // v24
    vq.push_back(mk(0,0,0,0,1, 0,    0,   0,  32'h300,      1, JT,             0, w(32'hFFFF_FFFC),32'h0,        0)); // v25 last wins
    vq.push_back(mk(0,1,0,0,0, 0,    0,   0,  0,            1, 32'h300,        0, w(32'hFFFF_FFFC),32'h0,        0));
    vq.push_back(mk(0,0,1,0,0, 32'h100, 0, 0, 0,            1, 32'h300,        0, w(32'hFFFF_FFFC),32'h0,        0)); // v27 DISCARD

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      stall = vq[i].stall; imem_ack = vq[i].ack; br_take = vq[i].br;
      jump = vq[i].jmp; jr = vq[i].jrr; redir_pc4 = vq[i].redir;
      br_offset = vq[i].off; jump_index = vq[i].idx; jr_target = vq[i].jrt;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_vld,
              vq[i].e_instr, vq[i].e_pc4, vq[i].e_aln);
    end

    // Asynchronous reset while in DISCARD, then restart at RESET_PC.
    #2;
    zero_inputs();
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_all("restart0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    imem_ack = 1'b1;
    @(posedge clk); #1;
    chk_all("restart1", 1'b1, 32'h4, 1'b1, w(32'h0), 32'h4, 1'b0);
    @(posedge clk); #1;
    chk_all("restart2", 1'b1, 32'h8, 1'b1, w(32'h4), 32'h8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
